// File: rtl/room_loader_pkg.sv
// rtl/room_loader_pkg.sv - shared types and helpers for the room image loader
package room_loader_pkg;

  localparam int CFG_ADDR_WIDTH = 32;
  localparam int CFG_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WR,
    ST_RD,
    ST_DONE
  } state_t;

  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Byte-enable pattern for a word holding n bytes, filled from lane 0 upward.
  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd3:    lane_mask = 4'b0111;
      3'd4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/room_loader_byte_packer.sv
// rtl/room_loader_byte_packer.sv - packs a byte stream little-endian into one 32-bit word
module byte_packer
  import room_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] data,
  output logic [3:0]  mask,
  output logic        full_next
);

  logic [2:0] count;

  // Unfilled lanes stay zero so a short final word carries no stale bytes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 3'd0;
      data  <= 32'd0;
    end else if (push && count != 3'd4) begin
      data[{count[1:0], 3'b000} +: 8] <= din;
      count <= count + 3'd1;
    end
  end

  assign mask      = lane_mask(count);
  assign full_next = (count == 3'd3);

endmodule

// File: rtl/room_loader.sv
// rtl/room_loader.sv - writes a byte-stream image into room word by word, with optional read-back compare
module room_loader
  import room_loader_pkg::*;
#(
  parameter int AW      = CFG_ADDR_WIDTH,
  parameter int DW      = CFG_DATA_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [AW-1:0]   i_base,
  input  logic [AW-1:0]   i_len,
  input  logic            i_verify,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  output logic            o_cmd_valid,
  output logic [AW-1:0]   o_cmd_addr,
  output logic            o_cmd_read,
  output logic [DW-1:0]   o_cmd_wdata,
  output logic [DW/8-1:0] o_cmd_wmask,
  input  logic            i_rsp_valid,
  input  logic            i_rsp_err,
  input  logic [DW-1:0]   i_rsp_rdata,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_timeout,
  output logic [7:0]      o_err_cnt,
  output logic [7:0]      o_mis_cnt
);

  localparam int TW = tmo_width(TIMEOUT);

  state_t        state;
  logic [AW-1:0] len_q;
  logic [AW-1:0] bytes_acc;
  logic          verify_q;
  logic [TW-1:0] tmo_cnt;

  logic          pk_clear;
  logic          pk_push;
  logic [31:0]   pk_data;
  logic [3:0]    pk_mask;
  logic          pk_full_next;
  logic [31:0]   byte_bits;

  logic start_ok;
  logic last_byte;
  logic word_end;
  logic more;
  logic mismatch;

  assign s_ready   = (state == ST_COLLECT);
  assign pk_push   = s_ready & s_valid;
  assign start_ok  = i_start & ((state == ST_IDLE) | (state == ST_DONE));
  assign last_byte = ((bytes_acc + AW'(1)) == len_q);
  assign more      = (bytes_acc != len_q);
  // A word is finished by its write response, or by its read response when verifying.
  assign word_end  = i_rsp_valid & (((state == ST_WR) & ~verify_q) | (state == ST_RD));
  assign pk_clear  = start_ok | (word_end & more);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .push      (pk_push),
    .din       (s_data),
    .data      (pk_data),
    .mask      (pk_mask),
    .full_next (pk_full_next)
  );

  always_comb begin
    byte_bits = '0;
    for (int i = 0; i < 4; i++) byte_bits[8*i +: 8] = {8{pk_mask[i]}};
  end

  assign mismatch    = |((i_rsp_rdata ^ pk_data) & byte_bits);
  assign o_cmd_wdata = pk_data;
  assign o_cmd_wmask = (state == ST_WR) ? pk_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      bytes_acc   <= '0;
      verify_q    <= 1'b0;
      tmo_cnt     <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_read  <= 1'b0;
      o_cmd_addr  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
      o_err_cnt   <= 8'd0;
      o_mis_cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            len_q      <= i_len;
            verify_q   <= i_verify;
            o_cmd_addr <= i_base & ~AW'(3);
            bytes_acc  <= '0;
            o_err_cnt  <= 8'd0;
            o_mis_cnt  <= 8'd0;
            o_timeout  <= 1'b0;
            if (i_len == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state  <= ST_COLLECT;
              o_done <= 1'b0;
              o_busy <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (pk_push) begin
            bytes_acc <= bytes_acc + AW'(1);
            if (pk_full_next || last_byte) begin
              state       <= ST_WR;
              o_cmd_valid <= 1'b1;
              o_cmd_read  <= 1'b0;
              tmo_cnt     <= '0;
            end
          end
        end
        ST_WR, ST_RD: begin
          if (i_rsp_valid) begin
            if (i_rsp_err) begin
              if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end else if (state == ST_RD && mismatch) begin
              if (o_mis_cnt != 8'hFF) o_mis_cnt <= o_mis_cnt + 8'd1;
            end
            if (state == ST_WR && verify_q) begin
              state      <= ST_RD;
              o_cmd_read <= 1'b1;
              tmo_cnt    <= '0;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state       <= ST_DONE;
            o_cmd_valid <= 1'b0;
            o_timeout   <= 1'b1;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Word retirement overrides the per-state updates above.
      if (word_end) begin
        o_cmd_valid <= 1'b0;
        if (more) begin
          state      <= ST_COLLECT;
          o_cmd_addr <= o_cmd_addr + AW'(4);
        end else begin
          state  <= ST_DONE;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_room_loader.sv
// tb/tb_room_loader.sv - self-checking bench for room_loader
module tb_room_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_base;
  logic [31:0] i_len;
  logic        i_verify;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        o_cmd_valid;
  logic [31:0] o_cmd_addr;
  logic        o_cmd_read;
  logic [31:0] o_cmd_wdata;
  logic [3:0]  o_cmd_wmask;
  logic        i_rsp_valid;
  logic        i_rsp_err;
  logic [31:0] i_rsp_rdata;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;
  logic [7:0]  o_err_cnt;
  logic [7:0]  o_mis_cnt;

  always #5 clk = ~clk;

  room_loader #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .i_verify(i_verify), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_cmd_valid(o_cmd_valid), .o_cmd_addr(o_cmd_addr), .o_cmd_read(o_cmd_read),
    .o_cmd_wdata(o_cmd_wdata), .o_cmd_wmask(o_cmd_wmask), .i_rsp_valid(i_rsp_valid),
    .i_rsp_err(i_rsp_err), .i_rsp_rdata(i_rsp_rdata), .o_busy(o_busy), .o_done(o_done),
    .o_timeout(o_timeout), .o_err_cnt(o_err_cnt), .o_mis_cnt(o_mis_cnt)
  );

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  cmd_t        exp_q[$];
  cmd_t        acc_q[$];
  logic [7:0]  img [0:15];
  logic [31:0] mem [logic [31:0]];

  int n_chk = 0, n_pass = 0;
  int lat = 0, err_idx = -1, corrupt_idx = -1;
  bit resp_on = 1'b0;
  logic [31:0] cur_base = 32'd0;
  int rsp_idx = 0, hold = 0, wait_cnt = 0, last_drop_hold = 0;
  int exp_err = 0, exp_mis = 0;
  int feed_n = 0;
  bit feeding = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Expected command list and counter totals derived from the image alone.
  task automatic build_model(input logic [31:0] base, input int len, input bit verify);
    int r = 0;
    exp_q.delete();
    exp_err = 0;
    exp_mis = 0;
    for (int w = 0; w < (len + 3) / 4; w++) begin
      cmd_t c;
      int nb;
      logic [31:0] bm;
      nb = (len - 4 * w > 4) ? 4 : len - 4 * w;
      c.rd = 1'b0;
      c.addr = (base & 32'hFFFF_FFFC) + 32'(4 * w);
      c.wdata = 32'd0;
      bm = 32'd0;
      for (int k = 0; k < nb; k++) begin
        c.wdata = c.wdata | (32'(img[4 * w + k]) << (8 * k));
        bm[8 * k +: 8] = 8'hFF;
      end
      c.wmask = 4'((1 << nb) - 1);
      exp_q.push_back(c);
      if (r == err_idx) exp_err++;
      r++;
      if (verify) begin
        c.rd = 1'b1;
        c.wmask = 4'd0;
        exp_q.push_back(c);
        if (r == err_idx) exp_err++;
        else if (w == corrupt_idx && ((32'hDEADBEEF ^ c.wdata) & bm) != 32'd0) exp_mis++;
        r++;
      end
    end
  endtask

  // Responder plus per-cycle command compare.
  initial begin : responder
    cmd_t a;
    i_rsp_valid = 1'b0;
    i_rsp_err = 1'b0;
    i_rsp_rdata = 32'd0;
    forever begin
      @(negedge clk);
      i_rsp_valid = 1'b0;
      i_rsp_err = 1'b0;
      i_rsp_rdata = 32'd0;
      if (rst) begin
        hold = 0;
        wait_cnt = 0;
      end else if (o_cmd_valid) begin
        hold++;
        chk("s_ready_during_cmd", s_ready, 1'b0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_cmd: got addr 0x%08h read %0d, expected no command", o_cmd_addr, o_cmd_read);
        end else begin
          chk("cmd_read", o_cmd_read, exp_q[0].rd);
          chk("cmd_addr", o_cmd_addr, exp_q[0].addr);
          chk("cmd_wmask", o_cmd_wmask, exp_q[0].wmask);
          if (!exp_q[0].rd) chk("cmd_wdata", o_cmd_wdata, exp_q[0].wdata);
        end
        if (resp_on && wait_cnt >= lat) begin
          a.rd = o_cmd_read;
          a.addr = o_cmd_addr;
          a.wdata = o_cmd_wdata;
          a.wmask = o_cmd_wmask;
          i_rsp_valid = 1'b1;
          i_rsp_err = (rsp_idx == err_idx);
          if (o_cmd_read) begin
            if (corrupt_idx >= 0 && o_cmd_addr == cur_base + 32'(4 * corrupt_idx))
              i_rsp_rdata = 32'hDEADBEEF;
            else if (mem.exists(o_cmd_addr))
              i_rsp_rdata = mem[o_cmd_addr];
          end else begin
            mem[o_cmd_addr] = o_cmd_wdata;
          end
          chk("cmd_hold", hold, lat + 1);
          acc_q.push_back(a);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          rsp_idx++;
          hold = 0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        if (hold > 0) last_drop_hold = hold;
        hold = 0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : feeder
    int i, guard;
    bit take;
    s_valid = 1'b0;
    s_data = 8'd0;
    forever begin
      @(negedge clk);
      if (feed_n > 0) begin
        i = 0;
        guard = 0;
        while (i < feed_n && guard < 400) begin
          s_valid = 1'b1;
          s_data = img[i];
          take = s_ready;
          @(posedge clk);
          if (take) i++;
          guard++;
          @(negedge clk);
        end
        s_valid = 1'b0;
        s_data = 8'd0;
        feed_n = 0;
        feeding = 1'b0;
      end
    end
  end

  task automatic run_load(input logic [31:0] base, input int len, input bit verify, input int nfeed);
    build_model(base, len, verify);
    acc_q.delete();
    mem.delete();
    rsp_idx = 0;
    cur_base = base & 32'hFFFF_FFFC;
    @(negedge clk);
    i_base = base;
    i_len = 32'(len);
    i_verify = verify;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (nfeed > 0) begin
      feeding = 1'b1;
      feed_n = nfeed;
    end
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!o_done && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(name, o_done, 1'b1);
    c = 0;
    while (feeding && c < 500) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_valid"}, o_cmd_valid, 1'b0);
    chk({tag, "_cmd_addr"}, o_cmd_addr, 32'd0);
    chk({tag, "_cmd_read"}, o_cmd_read, 1'b0);
    chk({tag, "_cmd_wdata"}, o_cmd_wdata, 32'd0);
    chk({tag, "_cmd_wmask"}, o_cmd_wmask, 4'd0);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_timeout"}, o_timeout, 1'b0);
    chk({tag, "_err_cnt"}, o_err_cnt, 8'd0);
    chk({tag, "_mis_cnt"}, o_mis_cnt, 8'd0);
  endtask

  task automatic load_img(input logic [63:0] v);
    for (int k = 0; k < 8; k++) img[k] = v[8 * k +: 8];
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_err_model"}, o_err_cnt, exp_err);
    chk({tag, "_mis_model"}, o_mis_cnt, exp_mis);
    chk({tag, "_cmds_left"}, exp_q.size(), 0);
    chk({tag, "_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    i_start = 1'b0;
    i_base = 32'd0;
    i_len = 32'd0;
    i_verify = 1'b0;
    for (int k = 0; k < 16; k++) img[k] = 8'd0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    // Two full words, zero-latency responder.
    load_img(64'h0010_0093_0000_0013);
    resp_on = 1'b1; lat = 0; err_idx = -1; corrupt_idx = -1;
    run_load(32'h0, 8, 1'b0, 8);
    wait_done("t1_done");
    chk_counts("t1");
    chk("t1_ncmd", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      chk("t1_w0_addr", acc_q[0].addr, 32'h0);
      chk("t1_w0_data", acc_q[0].wdata, 32'h0000_0013);
      chk("t1_w0_mask", acc_q[0].wmask, 4'hF);
      chk("t1_w1_addr", acc_q[1].addr, 32'h4);
      chk("t1_w1_data", acc_q[1].wdata, 32'h0010_0093);
      chk("t1_w1_mask", acc_q[1].wmask, 4'hF);
    end
    chk("t1_err", o_err_cnt, 8'd0);

    // Partial final word, unaligned base, 2-cycle latency.
    for (int k = 0; k < 8; k++) img[k] = 8'(k + 1);
    lat = 2;
    run_load(32'h3, 6, 1'b0, 6);
    wait_done("t2_done");
    chk_counts("t2");
    chk("t2_ncmd", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      chk("t2_w1_addr", acc_q[1].addr, 32'h4);
      chk("t2_w1_data", acc_q[1].wdata, 32'h0000_0605);
      chk("t2_w1_mask", acc_q[1].wmask, 4'b0011);
    end

    // Verify with word 1 read back as 0xDEADBEEF.
    load_img(64'h0010_0093_0000_0013);
    lat = 1; corrupt_idx = 1;
    run_load(32'h2000, 8, 1'b1, 8);
    wait_done("t3_done");
    chk_counts("t3");
    chk("t3_mis", o_mis_cnt, 8'd1);
    chk("t3_ncmd", acc_q.size(), 4);
    if (acc_q.size() >= 4)
      chk("t3_rw_order", {acc_q[0].rd, acc_q[1].rd, acc_q[2].rd, acc_q[3].rd}, 4'b0101);

    // Error on the first write.
    lat = 0; corrupt_idx = -1; err_idx = 0;
    run_load(32'h40, 8, 1'b0, 8);
    wait_done("t4_done");
    chk_counts("t4");
    chk("t4_err", o_err_cnt, 8'd1);
    chk("t4_ncmd", acc_q.size(), 2);
    if (acc_q.size() >= 2) chk("t4_w1_addr", acc_q[1].addr, 32'h44);
    err_idx = -1;

    // Silent responder: abort after 16 cycles.
    resp_on = 1'b0;
    run_load(32'h100, 4, 1'b0, 4);
    wait_done("t5_done");
    chk("t5_hold", last_drop_hold, 16);
    chk("t5_timeout", o_timeout, 1'b1);
    chk("t5_s_ready", s_ready, 1'b0);
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_valid", o_cmd_valid, 1'b0);
    exp_q.delete();

    // Reset while a write is outstanding.
    run_load(32'h0, 8, 1'b0, 4);
    c = 0;
    while (!o_cmd_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reach_wr", o_cmd_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("t6_rst");
    exp_q.delete();
    c = 0;
    while (feeding && c < 500) begin
      @(negedge clk);
      c++;
    end

    // Zero length from idle: done one cycle after start, no command.
    run_load(32'h80, 0, 1'b0, 0);
    chk("t7_done", o_done, 1'b1);
    chk("t7_busy", o_busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("t7_valid", o_cmd_valid, 1'b0);

    // Fresh load after reset.
    load_img(64'h0010_0093_0000_0013);
    resp_on = 1'b1; lat = 1;
    run_load(32'h0, 8, 1'b0, 8);
    wait_done("t8_done");
    chk_counts("t8");
    chk("t8_ncmd", acc_q.size(), 2);
    chk("t8_timeout", o_timeout, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
